// File: rtl/magic_request_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | magic_request_pkg : shared helper functions for the magic-request block    |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
package magic_request_pkg;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold every value 0..max_count inclusive (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/magic_request_debounce.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | magic_request_debounce : generic level debouncer for front-panel inputs    |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module magic_request_debounce
    import magic_request_pkg::*;
#(
    parameter int unsigned CYCLES      = 28000,
    parameter logic        RESET_LEVEL = 1'b1
) (
    input  logic clk28,
    input  logic rst_n,
    input  logic in,
    output logic out
);

    localparam int unsigned    CW   = cnt_width(CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;

    // Any sample matching the current level restarts the stability run.
    always_comb begin
        cnt_d = '0;
        out_d = out_q;
        if (in != out_q) begin
            if (cnt_q == LAST) begin
                out_d = in;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            out_q <= RESET_LEVEL;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule
`default_nettype wire

// File: rtl/magic_request.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | magic_request : turns button press / hotkey into a held magic request      |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module magic_request
    import magic_request_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 28000,
    parameter int unsigned TIMEOUT_FRAMES  = 4,
    parameter int unsigned HOLDOFF_FRAMES  = 25
) (
    input  logic clk28,
    input  logic rst_n,
    input  logic btn_n,
    input  logic hotkey,
    input  logic n_int,
    input  logic magic_mode,
    output logic magic_button,
    output logic busy,
    output logic req_timeout
);

    localparam int unsigned   FW      = cnt_width(max_u(TIMEOUT_FRAMES, HOLDOFF_FRAMES));
    localparam logic [FW-1:0] TO_LAST = FW'(TIMEOUT_FRAMES - 1);
    localparam logic [FW-1:0] HO_LAST = FW'(HOLDOFF_FRAMES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_ACTIVE  = 2'd2;
    localparam logic [1:0] S_HOLDOFF = 2'd3;

    logic          sync1_q, sync2_q, deb_prev_q, n_int_q;
    logic          deb_level;
    logic [1:0]    state_q, state_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d, frame_inc;
    logic          timeout_evt;
    logic          magic_button_q, magic_button_d;
    logic          busy_q, busy_d;
    logic          req_timeout_q, req_timeout_d;
    logic          press, frame_tick, ev;

    magic_request_debounce #(
        .CYCLES      (DEBOUNCE_CYCLES),
        .RESET_LEVEL (1'b1)
    ) u_debounce (
        .clk28 (clk28),
        .rst_n (rst_n),
        .in    (sync2_q),
        .out   (deb_level)
    );

    assign press      = deb_prev_q & ~deb_level;
    assign frame_tick = n_int_q & ~n_int;
    assign ev         = press | hotkey;
    assign frame_inc  = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + 1'b1;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q        <= 1'b1;
            sync2_q        <= 1'b1;
            deb_prev_q     <= 1'b1;
            n_int_q        <= 1'b1;
            state_q        <= S_IDLE;
            frame_cnt_q    <= '0;
            magic_button_q <= 1'b0;
            busy_q         <= 1'b0;
            req_timeout_q  <= 1'b0;
        end else begin
            sync1_q        <= btn_n;
            sync2_q        <= sync1_q;
            deb_prev_q     <= deb_level;
            n_int_q        <= n_int;
            state_q        <= state_d;
            frame_cnt_q    <= frame_cnt_d;
            magic_button_q <= magic_button_d;
            busy_q         <= busy_d;
            req_timeout_q  <= req_timeout_d;
        end
    end

    // Acknowledge wins over a timeout that lands on the same frame tick.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        timeout_evt = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ev && !magic_mode) begin
                    state_d     = S_REQ;
                    frame_cnt_d = '0;
                end
            end
            S_REQ: begin
                if (magic_mode) begin
                    state_d = S_ACTIVE;
                end else if (frame_tick) begin
                    if (frame_cnt_q == TO_LAST) begin
                        state_d     = S_HOLDOFF;
                        frame_cnt_d = '0;
                        timeout_evt = 1'b1;
                    end else begin
                        frame_cnt_d = frame_inc;
                    end
                end
            end
            S_ACTIVE: begin
                if (!magic_mode) begin
                    state_d     = S_HOLDOFF;
                    frame_cnt_d = '0;
                end
            end
            S_HOLDOFF: begin
                if (frame_tick) begin
                    if (frame_cnt_q == HO_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        frame_cnt_d = frame_inc;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        magic_button_d = (state_d == S_REQ);
        busy_d         = (state_d != S_IDLE);
        req_timeout_d  = timeout_evt;
    end

    assign magic_button = magic_button_q;
    assign busy         = busy_q;
    assign req_timeout  = req_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_magic_request.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_magic_request : scoreboard bench with a behavioural model of magic_request |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module tb_magic_request;

    localparam int DEB   = 8;
    localparam int TO    = 2;
    localparam int HO    = 3;
    localparam int FRAME = 100;

    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_ACT  = 2;
    localparam int P_HOLD = 3;

    logic clk28      = 1'b0;
    logic rst_n      = 1'b0;
    logic btn_n      = 1'b1;
    logic hotkey     = 1'b0;
    logic n_int      = 1'b1;
    logic magic_mode = 1'b0;
    logic magic_button, busy, req_timeout;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        string name;
        int    got;
        int    exp;
    } dchk_t;

    logic [2:0] exp_q[$];
    dchk_t      dir_q[$];

    // model state
    int ph;
    int ticks;
    bit m_tmo;
    bit deb;
    bit press_pend;
    bit nint_prev;
    bit pipe[$];
    bit win[$];

    magic_request #(
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_FRAMES  (TO),
        .HOLDOFF_FRAMES  (HO)
    ) dut (
        .clk28        (clk28),
        .rst_n        (rst_n),
        .btn_n        (btn_n),
        .hotkey       (hotkey),
        .n_int        (n_int),
        .magic_mode   (magic_mode),
        .magic_button (magic_button),
        .busy         (busy),
        .req_timeout  (req_timeout)
    );

    always #5 clk28 = ~clk28;

    initial begin : frame_gen
        forever begin
            @(negedge clk28);
            cyc++;
            n_int = (cyc % FRAME == FRAME - 1) ? 1'b0 : 1'b1;
        end
    end

    task automatic model_reset();
        ph         = P_IDLE;
        ticks      = 0;
        m_tmo      = 1'b0;
        deb        = 1'b1;
        press_pend = 1'b0;
        nint_prev  = 1'b1;
        pipe.delete();
        pipe.push_back(1'b1);
        pipe.push_back(1'b1);
        win.delete();
    endtask

    // One clock of the reference: a request phase plus a delayed, debounced pin.
    task automatic model_step();
        bit ev, tick, seen, stable;
        ev    = press_pend || hotkey;
        tick  = nint_prev && !n_int;
        m_tmo = 1'b0;
        case (ph)
            P_IDLE: if (ev && !magic_mode) begin ph = P_REQ; ticks = 0; end
            P_REQ: begin
                if (magic_mode) ph = P_ACT;
                else if (tick) begin
                    ticks++;
                    if (ticks == TO) begin ph = P_HOLD; ticks = 0; m_tmo = 1'b1; end
                end
            end
            P_ACT: if (!magic_mode) begin ph = P_HOLD; ticks = 0; end
            default: begin
                if (tick) begin
                    ticks++;
                    if (ticks == HO) ph = P_IDLE;
                end
            end
        endcase
        seen = pipe.pop_front();
        pipe.push_back(btn_n);
        press_pend = 1'b0;
        win.push_back(seen);
        if (win.size() > DEB) void'(win.pop_front());
        stable = (win.size() == DEB);
        foreach (win[i]) if (win[i] == deb) stable = 1'b0;
        if (stable) begin
            press_pend = deb && !seen;
            deb        = seen;
            win.delete();
        end
        nint_prev = n_int;
        exp_q.push_back({ph == P_REQ, ph != P_IDLE, m_tmo});
    endtask

    initial begin : model
        model_reset();
        forever begin
            @(posedge clk28 or negedge rst_n);
            if (!rst_n) begin
                model_reset();
                if (clk28) exp_q.push_back(3'b000);
            end else begin
                model_step();
            end
        end
    end

    initial begin : monitor
        logic [2:0] e;
        logic [2:0] got;
        dchk_t      c;
        forever begin
            @(negedge clk28);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {magic_button, busy, req_timeout};
                tests++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL outputs @%0t: mb/busy/tmo got %b required %b", $time, got, e);
                end
            end
            while (dir_q.size() > 0) begin
                c = dir_q.pop_front();
                tests++;
                if (c.got != c.exp) begin
                    fails++;
                    $display("FAIL %s @%0t: got %0d required %0d", c.name, $time, c.got, c.exp);
                end
            end
        end
    end

    task automatic post(input string nm, input int got, input int exp);
        dchk_t c;
        c.name = nm;
        c.got  = got;
        c.exp  = exp;
        dir_q.push_back(c);
    endtask

    task automatic pulse_hotkey();
        @(negedge clk28);
        hotkey = 1'b1;
        @(negedge clk28);
        hotkey = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk28);
            if (!busy) return;
        end
        post(nm, 0, 1);
    endtask

    task automatic wait_button(input string nm, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk28);
            if (magic_button) return;
        end
        post(nm, 0, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int lat;
        int nt;
        repeat (3) @(negedge clk28);
        post("reset_mb", magic_button, 0);
        post("reset_busy", busy, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk28);

        // 1: clean press, acknowledge, holdoff
        @(negedge clk28);
        btn_n = 1'b0;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk28);
            #1;
            if (magic_button && lat == 0) lat = i;
        end
        post("press_latency", lat, 11);
        @(negedge clk28);
        magic_mode = 1'b1;
        @(posedge clk28);
        #1;
        post("ack_drops_button", magic_button, 0);
        @(negedge clk28);
        btn_n = 1'b1;
        repeat (10) @(negedge clk28);
        magic_mode = 1'b0;
        wait_idle("wait_idle_1", 500);

        // 2: short glitch is not a press
        @(negedge clk28);
        btn_n = 1'b0;
        repeat (5) @(negedge clk28);
        btn_n = 1'b1;
        repeat (30) @(negedge clk28);
        post("glitch_busy", busy, 0);

        // 3: unacknowledged hotkey times out
        pulse_hotkey();
        wait_idle("wait_idle_3", 800);

        // 4: events during ACTIVE and HOLDOFF are dropped
        pulse_hotkey();
        wait_button("wait_button_4", 5);
        @(negedge clk28);
        magic_mode = 1'b1;
        repeat (5) @(negedge clk28);
        pulse_hotkey();
        repeat (3) @(negedge clk28);
        magic_mode = 1'b0;
        repeat (30) @(negedge clk28);
        pulse_hotkey();
        wait_idle("wait_idle_4", 500);
        repeat (20) @(negedge clk28);
        post("no_requeue", magic_button, 0);

        // 5a: press and hotkey in the same cycle
        @(negedge clk28);
        btn_n = 1'b0;
        repeat (10) @(negedge clk28);
        hotkey = 1'b1;
        @(negedge clk28);
        hotkey = 1'b0;
        repeat (3) @(negedge clk28);
        magic_mode = 1'b1;
        btn_n = 1'b1;
        repeat (15) @(negedge clk28);
        magic_mode = 1'b0;
        wait_idle("wait_idle_5a", 500);

        // 5b: acknowledge on the timeout tick
        pulse_hotkey();
        nt = 0;
        for (int i = 0; i < 400 && nt < 2; i++) begin
            @(negedge clk28);
            #1;
            if (!n_int) begin
                nt++;
                if (nt == 2) magic_mode = 1'b1;
            end
        end
        post("timeout_tick_seen", nt, 2);
        @(posedge clk28);
        #1;
        post("ack_beats_timeout", req_timeout, 0);
        repeat (6) @(negedge clk28);
        magic_mode = 1'b0;
        wait_idle("wait_idle_5b", 500);

        // 6: async reset in REQ
        pulse_hotkey();
        repeat (3) @(negedge clk28);
        #1;
        rst_n = 1'b0;
        #1;
        post("async_rst_mb", magic_button, 0);
        post("async_rst_busy", busy, 0);
        repeat (3) @(negedge clk28);
        #1;
        rst_n = 1'b1;
        pulse_hotkey();
        wait_button("wait_button_6", 5);
        @(negedge clk28);
        magic_mode = 1'b1;
        repeat (4) @(negedge clk28);
        magic_mode = 1'b0;
        wait_idle("wait_idle_6", 500);

        // randomized traffic
        repeat (3000) begin
            @(negedge clk28);
            hotkey = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 11) == 0) btn_n = ~btn_n;
            if (magic_button && $urandom_range(0, 29) == 0) magic_mode = 1'b1;
            else if ($urandom_range(0, 149) == 0) magic_mode = ~magic_mode;
        end
        @(negedge clk28);
        hotkey     = 1'b0;
        magic_mode = 1'b0;
        btn_n      = 1'b1;
        wait_idle("wait_idle_rand", 1000);

        repeat (3) @(negedge clk28);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
